// File: rtl/serial_operand_feeder.sv
// -----------------------------------------------------------------------------
// serial_operand_feeder
//
// Front end for the serial magnitude comparator. On an accepted start request
// it captures two N-bit operands in parallel, then presents them MSB-first,
// one bit pair per clock, on a_out/b_out. It also sequences the comparator's
// reset (comp_rst) and op inputs, so that the comparator's L/E/G result is
// valid and held once the LSB has been consumed. Every output is registered.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   begin a comparison (accepted in IDLE and HOLD only)
//   A, B     in   N-bit operands, captured on the accepted start edge
//   a_out    out  serial bit of A presented to the comparator
//   b_out    out  serial bit of B presented to the comparator
//   comp_rst out  comparator reset, high clears it
//   op_out   out  comparator op: 0 while bits stream, 1 once all N are delivered
//   busy     out  comparison in progress
//   done     out  one-cycle pulse after the last bit has been consumed
// -----------------------------------------------------------------------------
module serial_operand_feeder #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         a_out,
   output logic         b_out,
   output logic         comp_rst,
   output logic         op_out,
   output logic         busy,
   output logic         done
);

   // Down-counter width; at least one bit so that N=1 still has a legal vector.
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CntLast = CW'(N - 1);
   localparam logic [CW-1:0] CntOne  = CW'(1);

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StShift,
      StHold
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  sa_q, sa_d;
   logic [N-1:0]  sb_q, sb_d;
   logic [N-1:0]  sa_shl, sb_shl;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          a_q, a_d;
   logic          b_q, b_d;
   logic          crst_q, crst_d;
   logic          op_q, op_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // The MSB of the shifted register is always the next bit to present, which
   // keeps the indexing legal even when N=1.
   assign sa_shl = sa_q << 1;
   assign sb_shl = sb_q << 1;

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         crst_q  <= 1'b1;
         op_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         crst_q  <= crst_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      crst_d  = crst_q;
      op_d    = op_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            crst_d = 1'b1;
            if (start) begin
               sa_d    = A;
               sb_d    = B;
               a_d     = A[N-1];
               b_d     = B[N-1];
               cnt_d   = CntLast;
               crst_d  = 1'b0;
               op_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = StShift;
            end
         end

         StShift: begin
            // The comparator consumes the presented pair on this edge; cnt==0
            // means the LSB is being consumed now.
            if (cnt_q == '0) begin
               a_d     = 1'b0;
               b_d     = 1'b0;
               op_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StHold;
            end else begin
               sa_d  = sa_shl;
               sb_d  = sb_shl;
               a_d   = sa_shl[N-1];
               b_d   = sb_shl[N-1];
               cnt_d = cnt_q - CntOne;
            end
         end

         StHold: begin
            // op=1 with the comparator out of reset freezes its result.
            op_d   = 1'b1;
            crst_d = 1'b0;
            if (start) begin
               sa_d    = A;
               sb_d    = B;
               crst_d  = 1'b1;
               op_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = StClear;
            end
         end

         StClear: begin
            // Comparator has been held in reset across exactly one edge.
            crst_d  = 1'b0;
            a_d     = sa_q[N-1];
            b_d     = sb_q[N-1];
            cnt_d   = CntLast;
            state_d = StShift;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign a_out    = a_q;
   assign b_out    = b_q;
   assign comp_rst = crst_q;
   assign op_out   = op_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
module tb_serial_operand_feeder;

   localparam int unsigned N = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         a_out;
   logic         b_out;
   logic         comp_rst;
   logic         op_out;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;

   serial_operand_feeder #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .A        (A),
      .B        (B),
      .a_out    (a_out),
      .b_out    (b_out),
      .comp_rst (comp_rst),
      .op_out   (op_out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference serial magnitude comparator: MSB-first, first differing bit
   // decides; op=1 holds; comp_rst clears to "equal".
   logic m_l, m_e, m_g;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         {m_l, m_e, m_g} <= 3'b010;
      end else if (comp_rst === 1'b1) begin
         {m_l, m_e, m_g} <= 3'b010;
      end else if (op_out === 1'b0 && m_e) begin
         if (a_out === 1'b1 && b_out === 1'b0) {m_l, m_e, m_g} <= 3'b001;
         else if (a_out === 1'b0 && b_out === 1'b1) {m_l, m_e, m_g} <= 3'b100;
      end
   end

   // Immediate asynchronous reset with no clock edge.
   task automatic test_reset();
      rst = 1'b0; start = 1'b0; A = '0; B = '0;
      #3 rst = 1'b1;
      #1;
      total++;
      if ({a_out, b_out, comp_rst, op_out, busy, done} !== 6'b001000) begin
         bad++;
         $display("FAIL reset_async: got %b want 001000",
                  {a_out, b_out, comp_rst, op_out, busy, done});
      end
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({a_out, b_out, comp_rst, op_out, busy, done} !== 6'b001000) begin
         bad++;
         $display("FAIL reset_idle: got %b want 001000",
                  {a_out, b_out, comp_rst, op_out, busy, done});
      end
   endtask

   // Start from IDLE with B2/4D; checks the bit stream and the done pulse.
   task automatic test_stream();
      logic [7:0] ea = 8'hB2;
      logic [7:0] eb = 8'h4D;
      A = ea; B = eb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; A = 8'h00; B = 8'hFF;  // late operand changes must not matter
      for (int k = 1; k <= 8; k++) begin
         total++;
         if (a_out !== ea[8-k] || b_out !== eb[8-k]) begin
            bad++;
            $display("FAIL stream_bit%0d: got a=%b b=%b want a=%b b=%b",
                     8 - k, a_out, b_out, ea[8-k], eb[8-k]);
         end
         total++;
         if ({busy, comp_rst, op_out, done} !== 4'b1000) begin
            bad++;
            $display("FAIL stream_ctl%0d: got %b want 1000", k, {busy, comp_rst, op_out, done});
         end
         @(posedge clk); #1;
      end
      total++;
      if ({busy, comp_rst, op_out, done, a_out, b_out} !== 6'b001100) begin
         bad++;
         $display("FAIL stream_done: got %b want 001100",
                  {busy, comp_rst, op_out, done, a_out, b_out});
      end
      total++;
      if ({m_l, m_e, m_g} !== 3'b001) begin
         bad++;
         $display("FAIL stream_result: got leg=%b want 001", {m_l, m_e, m_g});
      end
      @(posedge clk); #1;
      total++;
      if ({busy, comp_rst, op_out, done} !== 4'b0010) begin
         bad++;
         $display("FAIL stream_pulse: got %b want 0010", {busy, comp_rst, op_out, done});
      end
   endtask

   // Three comparisons launched from HOLD; result held for 20 cycles.
   task automatic test_integration();
      logic [7:0] ta [3] = '{8'h5A, 8'h3C, 8'h01};
      logic [7:0] tb [3] = '{8'h5A, 8'h3A, 8'h80};
      logic [2:0] tr [3] = '{3'b010, 3'b001, 3'b100};
      for (int i = 0; i < 3; i++) begin
         int c = 0;
         int dev = 0;
         A = ta[i]; B = tb[i]; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         do begin
            @(posedge clk); #1;
            c++;
         end while (done !== 1'b1 && c < 30);
         total++;
         if (c !== 9) begin
            bad++;
            $display("FAIL integ%0d_latency: got %0d cycles want 9", i, c);
         end
         total++;
         if ({m_l, m_e, m_g} !== tr[i]) begin
            bad++;
            $display("FAIL integ%0d_result: got leg=%b want %b", i, {m_l, m_e, m_g}, tr[i]);
         end
         for (int h = 0; h < 20; h++) begin
            @(posedge clk); #1;
            if ({m_l, m_e, m_g} !== tr[i] || op_out !== 1'b1 || done !== 1'b0 ||
                comp_rst !== 1'b0)
               dev++;
         end
         total++;
         if (dev !== 0) begin
            bad++;
            $display("FAIL integ%0d_hold: got %0d unstable cycles want 0", i, dev);
         end
      end
   endtask

   // Back-to-back restart from HOLD: one CLEAR cycle, then a fresh result.
   task automatic test_back_to_back();
      int c = 1;
      A = 8'h10; B = 8'h20; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if ({busy, comp_rst, op_out, done} !== 4'b1100) begin
         bad++;
         $display("FAIL b2b_clear: got %b want 1100", {busy, comp_rst, op_out, done});
      end
      @(posedge clk); #1;
      total++;
      if ({busy, comp_rst, op_out, done, a_out, b_out} !== 6'b100000) begin
         bad++;
         $display("FAIL b2b_first: got %b want 100000",
                  {busy, comp_rst, op_out, done, a_out, b_out});
      end
      while (done !== 1'b1 && c < 30) begin
         @(posedge clk); #1;
         c++;
      end
      total++;
      if (c !== 9) begin
         bad++;
         $display("FAIL b2b_latency: got %0d cycles want 9", c);
      end
      total++;
      if ({m_l, m_e, m_g} !== 3'b100) begin
         bad++;
         $display("FAIL b2b_result: got leg=%b want 100", {m_l, m_e, m_g});
      end
   endtask

   // start pulsed during SHIFT must be ignored.
   task automatic test_ignore_start();
      logic [7:0] ea = 8'hC3;
      logic [7:0] eb = 8'h3C;
      int errs = 0;
      A = ea; B = eb; start = 1'b1;
      @(posedge clk); #1;             // HOLD -> CLEAR
      start = 1'b0;
      @(posedge clk); #1;             // CLEAR -> SHIFT, MSB presented
      for (int k = 1; k <= 8; k++) begin
         if (a_out !== ea[8-k] || b_out !== eb[8-k]) errs++;
         if (k == 3) begin
            start = 1'b1; A = 8'h00; B = 8'hFF;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      total++;
      if (errs !== 0) begin
         bad++;
         $display("FAIL ignore_stream: got %0d wrong bits want 0", errs);
      end
      total++;
      if ({done, op_out, busy} !== 3'b110) begin
         bad++;
         $display("FAIL ignore_done: got %b want 110", {done, op_out, busy});
      end
      total++;
      if ({m_l, m_e, m_g} !== 3'b001) begin
         bad++;
         $display("FAIL ignore_result: got leg=%b want 001", {m_l, m_e, m_g});
      end
   endtask

   // Reset in the middle of SHIFT, then a clean run from IDLE.
   task automatic test_mid_reset();
      logic [7:0] ea = 8'hFF;
      logic [7:0] eb = 8'hFE;
      int errs = 0;
      A = 8'h5A; B = 8'hA5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({a_out, b_out, comp_rst, op_out, busy, done} !== 6'b001000) begin
         bad++;
         $display("FAIL midrst_async: got %b want 001000",
                  {a_out, b_out, comp_rst, op_out, busy, done});
      end
      @(posedge clk); #1 rst = 1'b0;
      A = ea; B = eb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (a_out !== ea[8-k] || b_out !== eb[8-k] || busy !== 1'b1) errs++;
         @(posedge clk); #1;
      end
      total++;
      if (errs !== 0) begin
         bad++;
         $display("FAIL midrst_stream: got %0d wrong cycles want 0", errs);
      end
      total++;
      if ({done, op_out, busy} !== 3'b110) begin
         bad++;
         $display("FAIL midrst_done: got %b want 110", {done, op_out, busy});
      end
      total++;
      if ({m_l, m_e, m_g} !== 3'b001) begin
         bad++;
         $display("FAIL midrst_result: got leg=%b want 001", {m_l, m_e, m_g});
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_integration();
      test_back_to_back();
      test_ignore_start();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
